// File: rtl/regfile_pkg.sv
// Shared defaults and types for the datapath register file.
// Optional write-through forwarding is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int REGFILE_WIDTH  = 64;
    localparam int REGFILE_DEPTH  = 16;
    localparam int REGFILE_SELECT = 4;

    typedef logic [REGFILE_SELECT-1:0] reg_addr_t;
    typedef logic [REGFILE_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address decode, range check, optional forwarding mux.
// Write info ports exist only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int SELECT = REGFILE_SELECT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [SELECT-1:0]            address,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
`ifdef REGFILE_BYPASS_EN
    input  logic                         write_en,
    input  logic [SELECT-1:0]            write_addr,
    input  logic [WIDTH-1:0]             write_data,
`endif
    output logic [WIDTH-1:0]             data
);

    logic [WIDTH-1:0] selected;
    logic [WIDTH-1:0] data_next;

    // Addresses at or beyond DEPTH match no entry, so they read as zero.
    always_comb begin
        selected = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == i[SELECT-1:0]) begin
                selected = mem[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        data_next = selected;
        if (write_en && (write_addr == address)) begin
            data_next = write_data;
        end
    end
`else
    assign data_next = selected;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
        end else if (enable) begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: storage array, one write port, two registered read ports.
// Define REGFILE_BYPASS_EN for write-through forwarding; default is read-before-write.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int SELECT = REGFILE_SELECT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic              cs,
    input  logic [SELECT-1:0] read_reg1,
    input  logic [SELECT-1:0] read_reg2,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2,
    input  logic [SELECT-1:0] write_register,
    input  logic [WIDTH-1:0]  write_data
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        write_en;
    logic                        read_en;

    assign write_en = cs & we;
    assign read_en  = cs & re;

    // Out-of-range write addresses match no entry and are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem <= '0;
        end else if (write_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_register == i[SELECT-1:0]) begin
                    mem[i] <= write_data;
                end
            end
        end
    end

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SELECT (SELECT)
    ) u_read_port1 (
        .clock      (clock),
        .reset      (reset),
        .enable     (read_en),
        .address    (read_reg1),
        .mem        (mem),
`ifdef REGFILE_BYPASS_EN
        .write_en   (write_en),
        .write_addr (write_register),
        .write_data (write_data),
`endif
        .data       (read_data1)
    );

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SELECT (SELECT)
    ) u_read_port2 (
        .clock      (clock),
        .reset      (reset),
        .enable     (read_en),
        .address    (read_reg2),
        .mem        (mem),
`ifdef REGFILE_BYPASS_EN
        .write_en   (write_en),
        .write_addr (write_register),
        .write_data (write_data),
`endif
        .data       (read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test plan followed by random traffic,
// compared against an array-based reference model; a 12-entry instance covers out-of-range addresses.
module tb_register_file;

    localparam int W       = 64;
    localparam int D_FULL  = 16;
    localparam int D_SMALL = 12;

    logic          clock;
    logic          reset;
    logic          re;
    logic          we;
    logic          cs;
    logic [3:0]    read_reg1;
    logic [3:0]    read_reg2;
    logic [3:0]    write_register;
    logic [W-1:0]  write_data;
    logic [W-1:0]  read_data1;
    logic [W-1:0]  read_data2;
    logic [W-1:0]  small_data1;
    logic [W-1:0]  small_data2;

    register_file #(.WIDTH(W), .DEPTH(D_FULL), .SELECT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .re             (re),
        .we             (we),
        .cs             (cs),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .write_register (write_register),
        .write_data     (write_data)
    );

    register_file #(.WIDTH(W), .DEPTH(D_SMALL), .SELECT(4)) dut_small (
        .clock          (clock),
        .reset          (reset),
        .re             (re),
        .we             (we),
        .cs             (cs),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .read_data1     (small_data1),
        .read_data2     (small_data2),
        .write_register (write_register),
        .write_data     (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] ref_full  [D_FULL];
    logic [W-1:0] ref_small [D_SMALL];
    logic [W-1:0] exp1, exp2, exp_s1, exp_s2;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] read_full(input logic [3:0] a);
        return ref_full[a];
    endfunction

    function automatic logic [W-1:0] read_small(input logic [3:0] a);
        if (int'(a) >= D_SMALL) return '0;
        return ref_small[a];
    endfunction

    // Reads see pre-edge contents; writes are applied afterwards.
    task automatic model_edge(input logic r, input logic c, input logic rd, input logic w,
                              input logic [3:0] a1, input logic [3:0] a2,
                              input logic [3:0] wa, input logic [W-1:0] wd);
        if (r) begin
            foreach (ref_full[i])  ref_full[i]  = '0;
            foreach (ref_small[i]) ref_small[i] = '0;
            exp1 = '0; exp2 = '0; exp_s1 = '0; exp_s2 = '0;
        end else begin
            if (c && rd) begin
                exp1   = read_full(a1);
                exp2   = read_full(a2);
                exp_s1 = read_small(a1);
                exp_s2 = read_small(a2);
`ifdef REGFILE_BYPASS_EN
                if (w && a1 == wa) begin exp1 = wd; exp_s1 = wd; end
                if (w && a2 == wa) begin exp2 = wd; exp_s2 = wd; end
`endif
            end
            if (c && w) begin
                ref_full[wa] = wd;
                if (int'(wa) < D_SMALL) ref_small[wa] = wd;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic rd, input logic w,
                         input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] wa, input logic [W-1:0] wd);
        reset = r; cs = c; re = rd; we = w;
        read_reg1 = a1; read_reg2 = a2; write_register = wa; write_data = wd;
        @(posedge clock);
        model_edge(r, c, rd, w, a1, a2, wa, wd);
        #1;
        check("rd1",       read_data1,  exp1);
        check("rd2",       read_data2,  exp2);
        check("small_rd1", small_data1, exp_s1);
        check("small_rd2", small_data2, exp_s2);
    endtask

    int vals [6] = '{23, 30, 37, 44, 21, 56};

    initial begin
        reset = 1'b1; cs = 1'b0; re = 1'b0; we = 1'b0;
        read_reg1 = '0; read_reg2 = '0; write_register = '0; write_data = '0;
        exp1 = '0; exp2 = '0; exp_s1 = '0; exp_s2 = '0;
        #2;

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 3, 15, 0, 0);
        check("reset_read1", read_data1, 64'd0);
        check("reset_read2", read_data2, 64'd0);

        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 0, 0, 4'(i), W'(vals[i]));
        cycle(0, 1, 1, 0, 0, 2, 0, 0);
        check("read_0", read_data1, 64'd23);
        check("read_2", read_data2, 64'd37);
        cycle(0, 1, 1, 0, 1, 3, 0, 0);
        check("read_1", read_data1, 64'd30);
        check("read_3", read_data2, 64'd44);
        cycle(0, 1, 1, 0, 4, 5, 0, 0);
        check("read_4", read_data1, 64'd21);
        check("read_5", read_data2, 64'd56);

        cycle(0, 0, 0, 1, 0, 0, 2, 99);
        cycle(0, 0, 1, 0, 7, 8, 0, 0);
        check("cs_hold1", read_data1, 64'd21);
        check("cs_hold2", read_data2, 64'd56);
        cycle(0, 1, 1, 0, 2, 2, 0, 0);
        check("cs_no_write", read_data1, 64'd37);

        cycle(0, 1, 1, 1, 1, 1, 1, 77);
`ifdef REGFILE_BYPASS_EN
        check("same_addr1", read_data1, 64'd77);
        check("same_addr2", read_data2, 64'd77);
`else
        check("same_addr1", read_data1, 64'd30);
        check("same_addr2", read_data2, 64'd30);
`endif
        cycle(0, 1, 1, 0, 1, 1, 0, 0);
        check("after_write", read_data1, 64'd77);

        cycle(0, 1, 0, 1, 0, 0, 4, 21);
        cycle(1, 1, 1, 1, 4, 0, 4, 5);
        cycle(0, 1, 1, 0, 4, 0, 0, 0);
        check("mid_reset1", read_data1, 64'd0);
        check("mid_reset2", read_data2, 64'd0);

        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 0, 0, 4'(i), W'(vals[i]));
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 'x, 'x, 'x, 'x);
        for (int i = 0; i < 6; i += 2) begin
            cycle(0, 1, 1, 0, 4'(i), 4'(i + 1), 0, 0);
            check("x_tol_a", read_data1, W'(vals[i]));
            check("x_tol_b", read_data2, W'(vals[i + 1]));
        end

        // Boundary: out-of-range addresses on the 12-entry instance.
        cycle(0, 1, 0, 1, 0, 0, 13, 64'h1234);
        cycle(0, 1, 1, 0, 13, 11, 0, 0);
        check("oor_read_small", small_data1, 64'd0);
        check("oor_write_full", read_data1, 64'h1234);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
